mem_port_arbiter: RTL and testbench

// - Shares port 0 of one true_dpbram between two requesters: req0 = tile loader (writes), req1 = Conv data mover (reads).
// - Round-robin, burst-locked grant; muxes addr/ce/we/d onto the BRAM port.
// - Routes the 1-cycle-latency q0 back to the issuing requester with a valid strobe.
// - Sits between the GEMM data movers and the activation/weight BRAMs.

---
 rtl/gemm_pkg.sv | 10 +
 rtl/arb_rd_tag_pipe.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gemm_pkg.sv
// gemm_pkg: shared arbiter state encoding, owner-id width and BRAM read latency.
package gemm_pkg;
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_OWN0 = 2'd1,
        ARB_OWN1 = 2'd2
    } arb_state_e;
    localparam int OWNER_W = 1;
    localparam int RD_LAT  = 1;
endpackage

// File: rtl/arb_rd_tag_pipe.sv
// arb_rd_tag_pipe: DEPTH-deep valid/owner shift register matching the BRAM read latency.
module arb_rd_tag_pipe
    import gemm_pkg::*;
#(
    parameter int DEPTH = RD_LAT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vld_i,
    input  logic [OWNER_W-1:0] own_i,
    output logic               vld_o,
    output logic [OWNER_W-1:0] own_o
);
    logic [DEPTH-1:0]              vld_q, vld_d;
    logic [DEPTH-1:0][OWNER_W-1:0] own_q, own_d;

    always_comb begin
        vld_d    = vld_q;
        own_d    = own_q;
        vld_d[0] = vld_i;
        own_d[0] = own_i;
        for (int i = 1; i < DEPTH; i++) begin
            vld_d[i] = vld_q[i-1];
            own_d[i] = own_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            own_q <= '0;
        end else begin
            vld_q <= vld_d;
            own_q <= own_d;
        end
    end

    assign vld_o = vld_q[DEPTH-1];
    assign own_o = own_q[DEPTH-1];
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin, burst-locked sharing of one BRAM port between two requesters.
// Define ARB_STATS_EN to add per-requester accepted-beat and wait-cycle counters.
module mem_port_arbiter
    import gemm_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 128,
    parameter int BURST_MAX  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_req,
    input  logic                  req0_last,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic                  req0_we,
    input  logic [DATA_WIDTH-1:0] req0_d,
    output logic                  req0_gnt,
    output logic [DATA_WIDTH-1:0] req0_q,
    output logic                  req0_q_valid,
    input  logic                  req1_req,
    input  logic                  req1_last,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic                  req1_we,
    input  logic [DATA_WIDTH-1:0] req1_d,
    output logic                  req1_gnt,
    output logic [DATA_WIDTH-1:0] req1_q,
    output logic                  req1_q_valid,
    output logic [ADDR_WIDTH-1:0] mem_addr0,
    output logic                  mem_ce0,
    output logic                  mem_we0,
    output logic [DATA_WIDTH-1:0] mem_d0,
    input  logic [DATA_WIDTH-1:0] mem_q0
`ifdef ARB_STATS_EN
    ,
    output logic [31:0]           req0_beats,
    output logic [31:0]           req0_wait,
    output logic [31:0]           req1_beats,
    output logic [31:0]           req1_wait
`endif
);
    localparam int CNT_W = $clog2(BURST_MAX + 1);

    arb_state_e         state_q, state_d;
    logic               rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic               own0, own1, acc, last, rel, cur_req, oth_req, we_sel;
    logic               tag_vld;
    logic [OWNER_W-1:0] tag_own;

    always_comb begin
        own0       = state_q == ARB_OWN0;
        own1       = state_q == ARB_OWN1;
        acc        = (own0 & req0_req) | (own1 & req1_req);
        last       = own1 ? req1_last : req0_last;
        we_sel     = own1 ? req1_we : req0_we;
        cur_req    = own1 ? req1_req : req0_req;
        oth_req    = own1 ? req0_req : req1_req;
        rel        = acc & (last | (beat_cnt_q == CNT_W'(BURST_MAX - 1)));
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = acc ? beat_cnt_q + 1'b1 : beat_cnt_q;
        if (!(own0 | own1)) begin
            state_d = (req1_req & (~req0_req | rr_ptr_q)) ? ARB_OWN1 :
                      req0_req ? ARB_OWN0 : ARB_IDLE;
        end else if (rel) begin
            // A forced release keeps the owner only when nobody else is waiting.
            rr_ptr_d   = own0;
            beat_cnt_d = '0;
            state_d    = oth_req ? (own0 ? ARB_OWN1 : ARB_OWN0) :
                         (cur_req & ~last) ? state_q : ARB_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            rr_ptr_q   <= 1'b0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign req0_gnt  = own0;
    assign req1_gnt  = own1;
    assign mem_ce0   = acc;
    assign mem_we0   = acc & we_sel;
    assign mem_addr0 = own0 ? req0_addr : own1 ? req1_addr : '0;
    assign mem_d0    = own0 ? req0_d : own1 ? req1_d : '0;

    arb_rd_tag_pipe #(.DEPTH(RD_LAT)) u_rd_tag (
        .clk   (clk),
        .rst   (rst),
        .vld_i (acc & ~we_sel),
        .own_i (OWNER_W'(own1)),
        .vld_o (tag_vld),
        .own_o (tag_own)
    );

    assign req0_q       = mem_q0;
    assign req1_q       = mem_q0;
    assign req0_q_valid = tag_vld & (tag_own == OWNER_W'(0));
    assign req1_q_valid = tag_vld & (tag_own == OWNER_W'(1));

`ifdef ARB_STATS_EN
    logic [31:0] req0_beats_q, req0_beats_d, req0_wait_q, req0_wait_d;
    logic [31:0] req1_beats_q, req1_beats_d, req1_wait_q, req1_wait_d;

    always_comb begin
        req0_beats_d = req0_beats_q + 32'(own0 & req0_req & ~&req0_beats_q);
        req1_beats_d = req1_beats_q + 32'(own1 & req1_req & ~&req1_beats_q);
        req0_wait_d  = req0_wait_q + 32'(~own0 & req0_req & ~&req0_wait_q);
        req1_wait_d  = req1_wait_q + 32'(~own1 & req1_req & ~&req1_wait_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req0_beats_q <= '0;
            req1_beats_q <= '0;
            req0_wait_q  <= '0;
            req1_wait_q  <= '0;
        end else begin
            req0_beats_q <= req0_beats_d;
            req1_beats_q <= req1_beats_d;
            req0_wait_q  <= req0_wait_d;
            req1_wait_q  <= req1_wait_d;
        end
    end

    assign req0_beats = req0_beats_q;
    assign req1_beats = req1_beats_q;
    assign req0_wait  = req0_wait_q;
    assign req1_wait  = req1_wait_q;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scenario tasks plus a read-return scoreboard against a behavioural BRAM.
module tb_mem_port_arbiter;
    localparam int AW = 10;
    localparam int DW = 128;
    localparam int BM = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_req, req0_last, req0_we, req1_req, req1_last, req1_we;
    logic [AW-1:0] req0_addr, req1_addr, mem_addr0;
    logic [DW-1:0] req0_d, req1_d, req0_q, req1_q, mem_d0, mem_q0;
    logic          req0_gnt, req1_gnt, req0_q_valid, req1_q_valid, mem_ce0, mem_we0;
`ifdef ARB_STATS_EN
    logic [31:0]   req0_beats, req0_wait, req1_beats, req1_wait;
`endif

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_MAX(BM)) dut (
        .clk(clk), .rst(rst),
        .req0_req(req0_req), .req0_last(req0_last), .req0_addr(req0_addr), .req0_we(req0_we),
        .req0_d(req0_d), .req0_gnt(req0_gnt), .req0_q(req0_q), .req0_q_valid(req0_q_valid),
        .req1_req(req1_req), .req1_last(req1_last), .req1_addr(req1_addr), .req1_we(req1_we),
        .req1_d(req1_d), .req1_gnt(req1_gnt), .req1_q(req1_q), .req1_q_valid(req1_q_valid),
        .mem_addr0(mem_addr0), .mem_ce0(mem_ce0), .mem_we0(mem_we0), .mem_d0(mem_d0),
        .mem_q0(mem_q0)
`ifdef ARB_STATS_EN
        , .req0_beats(req0_beats), .req0_wait(req0_wait),
        .req1_beats(req1_beats), .req1_wait(req1_wait)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural BRAM with a preload path used only while the arbiter is in reset.
    logic [DW-1:0] bram [0:1023];
    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [DW-1:0] pl_d;
    always @(posedge clk) begin
        if (pl_en) bram[pl_addr] <= pl_d;
        else if (mem_ce0) begin
            if (mem_we0) bram[mem_addr0] <= mem_d0;
            else mem_q0 <= bram[mem_addr0];
        end
    end

    typedef struct packed {
        logic          own;
        logic [DW-1:0] data;
    } rd_t;

    logic [DW-1:0] exp_mem [0:1023];
    rd_t           sb[$];
    int            vectors = 0;
    int            errors = 0;
    logic          o_g0, o_g1, o_ce, o_we;
    logic [AW-1:0] o_addr;

    // Observes the beat about to be accepted, then checks read returns after the edge.
    task automatic step();
        rd_t        e;
        logic [1:0] exp_v;
        #1;
        o_g0   = req0_gnt;
        o_g1   = req1_gnt;
        o_ce   = mem_ce0;
        o_we   = mem_we0;
        o_addr = mem_addr0;
        if (o_ce && o_we) exp_mem[o_addr] = o_g1 ? req1_d : req0_d;
        else if (o_ce) sb.push_back('{own: o_g1, data: exp_mem[o_addr]});
        @(posedge clk);
        #1;
        exp_v = 2'b00;
        e     = '0;
        if (sb.size() > 0) begin
            e     = sb.pop_front();
            exp_v = e.own ? 2'b10 : 2'b01;
        end
        vectors++;
        if ({req1_q_valid, req0_q_valid} !== exp_v) begin
            errors++;
            $display("FAIL q_valid: got %b expected %b at %0t", {req1_q_valid, req0_q_valid}, exp_v, $time);
        end
        if (exp_v != 2'b00) begin
            vectors++;
            if ((e.own ? req1_q : req0_q) !== e.data) begin
                errors++;
                $display("FAIL rd_data: got %h expected %h", e.own ? req1_q : req0_q, e.data);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        req0_req = 0; req0_last = 0; req0_we = 0; req0_addr = '0; req0_d = '0;
        req1_req = 0; req1_last = 0; req1_we = 0; req1_addr = '0; req1_d = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        sb.delete();
        @(negedge clk);
        rst = 0;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pl_en = 1; pl_addr = a; pl_d = d;
        exp_mem[a] = d;
        @(negedge clk);
        pl_en = 0;
    endtask

    task automatic test_reset();
        req0_req = 1; req0_addr = '1; req0_d = '1; req0_we = 1;
        #1;
        vectors++;
        if ({req0_gnt, req1_gnt, mem_ce0, mem_we0, req0_q_valid, req1_q_valid} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {req0_gnt, req1_gnt, mem_ce0, mem_we0, req0_q_valid, req1_q_valid});
        end
        vectors++;
        if (mem_addr0 !== '0) begin
            errors++;
            $display("FAIL reset_addr: got %h expected 0", mem_addr0);
        end
        vectors++;
        if (mem_d0 !== '0) begin
            errors++;
            $display("FAIL reset_d: got %h expected 0", mem_d0);
        end
        @(negedge clk);
        idle_inputs();
        rst = 0;
    endtask

    task automatic test_write_burst();
        do_reset();
        req0_req = 1; req0_we = 1; req0_addr = '0;
        step();
        vectors++;
        if ({o_g0, o_ce} !== 2'b00) begin
            errors++;
            $display("FAIL gnt_latency: got gnt/ce %b expected 00", {o_g0, o_ce});
        end
        for (int b = 0; b < 4; b++) begin
            req0_addr = AW'(b);
            req0_d    = {8{16'(16'h1100 + b)}};
            req0_last = (b == 3);
            step();
            vectors++;
            if ({o_g0, o_ce, o_we, o_addr} !== {3'b111, AW'(b)}) begin
                errors++;
                $display("FAIL wr_beat%0d: got %b/%h expected 111/%h", b, {o_g0, o_ce, o_we}, o_addr, AW'(b));
            end
        end
        req0_req = 0; req0_last = 0; req0_we = 0;
        step();
        vectors++;
        if ({o_g0, o_g1, o_ce} !== 3'b000) begin
            errors++;
            $display("FAIL wr_idle_after: got %b expected 000", {o_g0, o_g1, o_ce});
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        req0_req = 1; req0_we = 1; req1_req = 1; req1_we = 0; req1_addr = AW'(2);
        step();
        for (int b = 0; b < 3; b++) begin
            req0_addr = AW'(10 + b);
            req0_d    = {4{32'(32'hC0DE0000 + b)}};
            req0_last = (b == 2);
            step();
            vectors++;
            if ({o_g0, o_g1, o_ce} !== 3'b101) begin
                errors++;
                $display("FAIL rr_first%0d: got %b expected 101", b, {o_g0, o_g1, o_ce});
            end
        end
        req0_req = 0; req0_last = 0; req1_last = 1;
        step();
        vectors++;
        if ({o_g0, o_g1, o_ce, o_we} !== 4'b0110) begin
            errors++;
            $display("FAIL rr_handover: got %b expected 0110", {o_g0, o_g1, o_ce, o_we});
        end
        req1_req = 0; req1_last = 0;
        step();
        vectors++;
        if ({o_g0, o_g1} !== 2'b00) begin
            errors++;
            $display("FAIL rr_idle_after: got %b expected 00", {o_g0, o_g1});
        end
    endtask

    task automatic test_read_return();
        do_reset();
        req1_req = 1; req1_we = 0; req1_addr = AW'(5);
        step();
        step();
        vectors++;
        if ({o_g1, o_ce, o_we, o_addr} !== {3'b110, AW'(5)}) begin
            errors++;
            $display("FAIL rd_beat5: got %b/%h expected 110/005", {o_g1, o_ce, o_we}, o_addr);
        end
        req1_addr = AW'(6); req1_last = 1;
        step();
        req1_req = 0; req1_last = 0;
        step();
        step();
        vectors++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL rd_outstanding: got %0d expected 0", sb.size());
        end
    endtask

    task automatic test_forced_release();
        int beats1 = 0;
        int stall = 0;
        int got_at = -1;
        do_reset();
        req1_req = 1; req1_we = 0; req1_addr = AW'(5);
        step();
        req0_req = 1; req0_we = 1; req0_addr = AW'(30); req0_last = 1; req0_d = {DW{1'b1}};
        for (int i = 0; i < 40; i++) begin
            req1_addr = i[0] ? AW'(6) : AW'(5);
            step();
            if (o_g0) begin
                got_at = i;
                break;
            end
            if (req0_req) stall++;
            if (o_g1 && o_ce) beats1++;
        end
        vectors++;
        if (beats1 !== BM) begin
            errors++;
            $display("FAIL forced_beats: got %0d expected %0d", beats1, BM);
        end
        vectors++;
        if (got_at !== BM) begin
            errors++;
            $display("FAIL forced_handover: got cycle %0d expected %0d", got_at, BM);
        end
`ifdef ARB_STATS_EN
        vectors++;
        if (req1_beats !== 32'(BM)) begin
            errors++;
            $display("FAIL stats_beats: got %0d expected %0d", req1_beats, BM);
        end
        vectors++;
        if (req0_wait !== 32'(stall)) begin
            errors++;
            $display("FAIL stats_wait: got %0d expected %0d", req0_wait, stall);
        end
`endif
        req0_req = 0; req0_last = 0; req1_req = 0;
        step();
        step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        req0_req = 1; req0_we = 1; req0_addr = AW'(40); req0_last = 1; req0_d = {DW/8{8'h3C}};
        step();
        step();
        req0_req = 0; req0_last = 0;
        req1_req = 1; req1_we = 0; req1_addr = AW'(5);
        step();
        req1_addr = AW'(6);
        step();
        vectors++;
        if ({req1_gnt, mem_ce0, req1_q_valid} !== 3'b111) begin
            errors++;
            $display("FAIL mid_pre: got %b expected 111", {req1_gnt, mem_ce0, req1_q_valid});
        end
        rst = 1;
        #1;
        vectors++;
        if ({req0_gnt, req1_gnt, mem_ce0, req0_q_valid, req1_q_valid} !== 5'b0) begin
            errors++;
            $display("FAIL mid_rst_drop: got %b expected 00000",
                     {req0_gnt, req1_gnt, mem_ce0, req0_q_valid, req1_q_valid});
        end
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        req0_req = 1; req0_we = 1; req0_addr = AW'(41); req0_last = 1;
        rst = 0;
        step();
        vectors++;
        if ({o_g0, o_g1} !== 2'b00) begin
            errors++;
            $display("FAIL mid_idle: got %b expected 00", {o_g0, o_g1});
        end
        step();
        vectors++;
        if ({o_g0, o_g1} !== 2'b10) begin
            errors++;
            $display("FAIL mid_rr_ptr: got %b expected 10", {o_g0, o_g1});
        end
        idle_inputs();
        step();
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        pl_en = 0; pl_addr = '0; pl_d = '0;
        rst = 1;
        @(negedge clk);
        preload(AW'(5), {16{8'hA5}});
        preload(AW'(6), {16{8'h5A}});
        test_reset();
        test_write_burst();
        test_round_robin();
        test_read_return();
        test_forced_release();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
